// File: rtl/rr_banked_scheduler_if.sv
// Consumer-side request/response bundle for rr_banked_scheduler.
// Fields are packed per consumer: consumer i sits at [i*W +: W].
interface rr_banked_scheduler_if #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 4
);
  logic [NCONSUMERS-1:0]             req_valid;
  logic [NCONSUMERS-1:0]             req_write;
  logic [NCONSUMERS*ADDR_WIDTH-1:0]  req_addr;
  logic [NCONSUMERS*VALUE_WIDTH-1:0] req_wdata;
  logic [NCONSUMERS-1:0]             req_grant;
  logic [NCONSUMERS-1:0]             rsp_valid;
  logic [NCONSUMERS*VALUE_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_grant, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_grant, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/rr_banked_scheduler.sv
// Banked round-robin scheduler: per-bank rotating-priority arbiters over
// NCONSUMERS requesters, NPORTS grants per bank per cycle, 1-cycle read data.

module rr_bank_arb #(
  parameter int NC = 4,
  parameter int NP = 1,
  parameter int PW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [NC-1:0] i_cand,
  output logic [NC-1:0] o_grant,
  output logic [PW-1:0] o_ptr
);
  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_ptr_nxt;
  logic [NC-1:0] w_grant;
  int            w_idx;
  int            w_cnt;
  int            w_last;

  // Walk candidates in rotation order from r_ptr, taking the first NP.
  always_comb begin
    w_grant = '0;
    w_idx   = 0;
    w_cnt   = 0;
    w_last  = 0;
    for (int k = 0; k < NC; k++) begin
      w_idx = int'(r_ptr) + k;
      if (w_idx >= NC) w_idx = w_idx - NC;
      if (i_cand[PW'(w_idx)] && (w_cnt < NP)) begin
        w_grant[PW'(w_idx)] = 1'b1;
        w_cnt               = w_cnt + 1;
        w_last              = w_idx;
      end
    end
    w_ptr_nxt = r_ptr;
    if (|w_grant) w_ptr_nxt = (w_last == NC - 1) ? '0 : PW'(w_last + 1);
  end

  always_ff @(posedge clk) begin
    if (reset) r_ptr <= '0;
    else       r_ptr <= w_ptr_nxt;
  end

  assign o_grant = w_grant;
  assign o_ptr   = r_ptr;
endmodule

module rr_banked_scheduler #(
  parameter int ADDR_WIDTH  = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS  = 4,
  parameter int NBANKS      = 2,
  parameter int NPORTS      = 1
) (
  input logic                  clk,
  input logic                  reset,
  rr_banked_scheduler_if.slave bus
);
  localparam int LB   = $clog2(NBANKS);
  localparam int BW   = (LB > 0) ? LB : 1;
  localparam int ROWS = (2 ** ADDR_WIDTH) / NBANKS;
  localparam int RW   = ($clog2(ROWS) > 0) ? $clog2(ROWS) : 1;
  localparam int PW   = ($clog2(NCONSUMERS) > 0) ? $clog2(NCONSUMERS) : 1;

  logic [NCONSUMERS-1:0][BW-1:0]          w_bank;
  logic [NCONSUMERS-1:0][RW-1:0]          w_row;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] w_wdata;
  logic [NCONSUMERS-1:0][VALUE_WIDTH-1:0] r_rsp_rdata;
  logic [NCONSUMERS-1:0]                  r_rsp_valid;
  logic [NCONSUMERS-1:0]                  w_grant;
  logic [NCONSUMERS-1:0]                  w_rd;
  logic [NBANKS-1:0][NCONSUMERS-1:0]      w_cand;
  logic [NBANKS-1:0][NCONSUMERS-1:0]      w_bgrant;
  logic [NBANKS-1:0][PW-1:0]              w_ptr;
  logic [NBANKS-1:0][ROWS-1:0][VALUE_WIDTH-1:0] r_mem;
  logic [NBANKS-1:0][ROWS-1:0][VALUE_WIDTH-1:0] w_wdat;
  logic [NBANKS-1:0][ROWS-1:0]            w_wen;
  int                                     w_widx;

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_dec
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_addr     = bus.req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata[c] = bus.req_wdata[c*VALUE_WIDTH +: VALUE_WIDTH];
    if (LB > 0) begin : g_split
      assign w_bank[c] = w_addr[BW-1:0];
      assign w_row[c]  = RW'(w_addr >> LB);
    end else begin : g_single
      assign w_bank[c] = '0;
      assign w_row[c]  = RW'(w_addr);
    end
  end

  // Reset masks candidates, so no grant and no write can occur while it is high.
  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    for (genvar c = 0; c < NCONSUMERS; c++) begin : g_cand
      assign w_cand[b][c] = bus.req_valid[c] && !reset && (int'(w_bank[c]) == b);
    end
    rr_bank_arb #(.NC(NCONSUMERS), .NP(NPORTS), .PW(PW)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .i_cand  (w_cand[b]),
      .o_grant (w_bgrant[b]),
      .o_ptr   (w_ptr[b])
    );
  end

  always_comb begin
    w_grant = '0;
    for (int b = 0; b < NBANKS; b++) w_grant = w_grant | w_bgrant[b];
  end

  assign w_rd = w_grant & ~bus.req_write;

  // Scan rotation order backwards so the earliest granted writer to a row
  // is assigned last and therefore wins.
  always_comb begin
    w_wen  = '0;
    w_wdat = '0;
    w_widx = 0;
    for (int b = 0; b < NBANKS; b++) begin
      for (int k = NCONSUMERS - 1; k >= 0; k--) begin
        w_widx = int'(w_ptr[b]) + k;
        if (w_widx >= NCONSUMERS) w_widx = w_widx - NCONSUMERS;
        if (w_bgrant[b][PW'(w_widx)] && bus.req_write[PW'(w_widx)]) begin
          w_wen[b][w_row[PW'(w_widx)]]  = 1'b1;
          w_wdat[b][w_row[PW'(w_widx)]] = w_wdata[PW'(w_widx)];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mem       <= '0;
      r_rsp_valid <= '0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= w_rd;
      for (int c = 0; c < NCONSUMERS; c++)
        if (w_rd[c]) r_rsp_rdata[c] <= r_mem[w_bank[c]][w_row[c]];
      for (int b = 0; b < NBANKS; b++)
        for (int r = 0; r < ROWS; r++)
          if (w_wen[b][r]) r_mem[b][r] <= w_wdat[b][r];
    end
  end

  assign bus.req_grant = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_rr_banked_scheduler.sv
// Bench for rr_banked_scheduler: directed vector table on NPORTS=1/2 instances,
// then random traffic against a flat-memory reference model.
module tb_rr_banked_scheduler;
  localparam int AW = 4, VW = 8, NC = 4, NB = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rr_banked_scheduler_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC)) ifa ();
  rr_banked_scheduler_if #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC)) ifb ();

  rr_banked_scheduler #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                        .NBANKS(NB), .NPORTS(1)) u_p1 (.clk(clk), .reset(reset), .bus(ifa));
  rr_banked_scheduler #(.ADDR_WIDTH(AW), .VALUE_WIDTH(VW), .NCONSUMERS(NC),
                        .NBANKS(NB), .NPORTS(2)) u_p2 (.clk(clk), .reset(reset), .bus(ifb));

  int errors = 0;
  int checks = 0;

  logic [1:0][NC-1:0]         s_v, s_w;
  logic [1:0][NC-1:0][AW-1:0] s_a;
  logic [1:0][NC-1:0][VW-1:0] s_d;

  typedef struct {
    bit          d;
    bit          rst;
    logic [3:0]  v, w;
    logic [15:0] a;
    logic [31:0] wd;
    logic [3:0]  eg, erv;
    int          rc;
    logic [7:0]  erd;
  } vec_t;
  vec_t tbl[$];

  // reference model state: flat word array per instance
  int         m_ptr[2][NB];
  logic [7:0] m_mem[2][16];
  logic [3:0] m_rv[2];
  logic [7:0] m_rd[2][NC];
  bit         pend[2][NC];
  int         wt[2][NC];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit d, bit rst, logic [3:0] v, logic [3:0] w, logic [15:0] a,
                              logic [31:0] wd, logic [3:0] eg, logic [3:0] erv, int rc,
                              logic [7:0] erd);
    vec_t t;
    t.d = d; t.rst = rst; t.v = v; t.w = w; t.a = a; t.wd = wd;
    t.eg = eg; t.erv = erv; t.rc = rc; t.erd = erd;
    return t;
  endfunction

  task automatic drive();
    ifa.req_valid = s_v[0]; ifa.req_write = s_w[0]; ifa.req_addr = s_a[0]; ifa.req_wdata = s_d[0];
    ifb.req_valid = s_v[1]; ifb.req_write = s_w[1]; ifb.req_addr = s_a[1]; ifb.req_wdata = s_d[1];
  endtask

  function automatic logic [3:0] mgrant(int d, int np);
    logic [3:0] g = '0;
    if (reset) return g;
    for (int b = 0; b < NB; b++) begin
      int n = 0;
      for (int k = 0; k < NC; k++) begin
        int c = (m_ptr[d][b] + k) % NC;
        if (s_v[d][c] && (int'(s_a[d][c]) % NB == b) && n < np) begin
          g[c] = 1'b1;
          n++;
        end
      end
    end
    return g;
  endfunction

  task automatic mupdate(input int d, input logic [3:0] g);
    if (reset) begin
      for (int b = 0; b < NB; b++) m_ptr[d][b] = 0;
      for (int i = 0; i < 16; i++) m_mem[d][i] = 8'h00;
      m_rv[d] = '0;
      for (int c = 0; c < NC; c++) m_rd[d][c] = 8'h00;
      return;
    end
    for (int c = 0; c < NC; c++) begin
      m_rv[d][c] = g[c] && !s_w[d][c];
      if (m_rv[d][c]) m_rd[d][c] = m_mem[d][s_a[d][c]];
    end
    for (int b = 0; b < NB; b++) begin
      bit done[16];
      int last = -1;
      for (int i = 0; i < 16; i++) done[i] = 1'b0;
      for (int k = 0; k < NC; k++) begin
        int c = (m_ptr[d][b] + k) % NC;
        if (g[c] && (int'(s_a[d][c]) % NB == b)) begin
          last = c;
          if (s_w[d][c] && !done[s_a[d][c]]) begin
            m_mem[d][s_a[d][c]] = s_d[d][c];
            done[s_a[d][c]] = 1'b1;
          end
        end
      end
      if (last >= 0) m_ptr[d][b] = (last + 1) % NC;
    end
  endtask

  initial begin
    logic [31:0] rd;
    logic [3:0]  gd, g0, g1;
    logic [31:0] exp_rd;

    reset = 1'b1;
    s_v = '0; s_w = '0; s_a = '0; s_d = '0;
    drive();

    tbl.push_back(mk(0, 1, 4'b0000, 4'b0000, 16'h0000, 32'h0, 4'b0000, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0000, 16'h0003, 32'h0, 4'b0001, 4'b0001, 0, 8'h00));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0010, 16'h0060, 32'h0000A500, 4'b0010, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0000, 16'h0600, 32'h0, 4'b0100, 4'b0100, 2, 8'hA5));
    tbl.push_back(mk(0, 0, 4'b0001, 4'b0001, 16'h0000, 32'h00000010, 4'b0001, 4'b0000, 2, 8'hA5));
    tbl.push_back(mk(0, 0, 4'b0010, 4'b0010, 16'h0020, 32'h00002100, 4'b0010, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(0, 0, 4'b0100, 4'b0100, 16'h0400, 32'h00420000, 4'b0100, 4'b0000, 2, 8'hA5));
    tbl.push_back(mk(0, 0, 4'b1000, 4'b1000, 16'h6000, 32'h63000000, 4'b1000, 4'b0000, 3, 8'h00));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0001, 4'b0001, 0, 8'h10));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0010, 4'b0010, 1, 8'h21));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0100, 4'b0100, 2, 8'h42));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b1000, 4'b1000, 3, 8'h63));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0001, 4'b0001, 0, 8'h10));
    tbl.push_back(mk(0, 0, 4'b0011, 4'b0000, 16'h0052, 32'h0, 4'b0011, 4'b0011, 0, 8'h21));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0010, 4'b0010, 1, 8'h21));
    tbl.push_back(mk(0, 1, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0000, 4'b0000, 1, 8'h00));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0001, 4'b0001, 0, 8'h00));
    tbl.push_back(mk(0, 0, 4'b1111, 4'b0000, 16'h6420, 32'h0, 4'b0010, 4'b0010, 1, 8'h00));
    tbl.push_back(mk(1, 0, 4'b0001, 4'b0001, 16'h0002, 32'h00000011, 4'b0001, 4'b0000, 0, 8'h00));
    tbl.push_back(mk(1, 0, 4'b1001, 4'b1000, 16'h2002, 32'h5A000000, 4'b1001, 4'b0001, 0, 8'h11));
    tbl.push_back(mk(1, 0, 4'b0010, 4'b0000, 16'h0020, 32'h0, 4'b0010, 4'b0010, 1, 8'h5A));
    tbl.push_back(mk(1, 0, 4'b0110, 4'b0110, 16'h0440, 32'h00887700, 4'b0110, 4'b0000, 1, 8'h5A));
    tbl.push_back(mk(1, 0, 4'b0001, 4'b0000, 16'h0004, 32'h0, 4'b0001, 4'b0001, 0, 8'h88));

    @(negedge clk);
    foreach (tbl[i]) begin
      s_v = '0; s_w = '0; s_a = '0; s_d = '0;
      s_v[tbl[i].d] = tbl[i].v;
      s_w[tbl[i].d] = tbl[i].w;
      s_a[tbl[i].d] = tbl[i].a;
      s_d[tbl[i].d] = tbl[i].wd;
      reset = tbl[i].rst;
      drive();
      #1;
      gd = tbl[i].d ? ifb.req_grant : ifa.req_grant;
      chk($sformatf("vec%0d grant", i), 32'(gd), 32'(tbl[i].eg));
      @(posedge clk);
      @(negedge clk);
      gd = tbl[i].d ? ifb.rsp_valid : ifa.rsp_valid;
      chk($sformatf("vec%0d rsp_valid", i), 32'(gd), 32'(tbl[i].erv));
      rd = tbl[i].d ? ifb.rsp_rdata : ifa.rsp_rdata;
      chk($sformatf("vec%0d rdata[%0d]", i, tbl[i].rc), 32'(rd[tbl[i].rc*8 +: 8]), 32'(tbl[i].erd));
    end

    // random traffic, ungranted requests held, occasional reset
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NC; c++) begin
        pend[d][c] = 1'b0;
        wt[d][c]   = 0;
      end
    s_v = '0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset = (cyc == 0) || ($urandom_range(0, 59) == 0);
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < NC; c++)
          if (!pend[d][c]) begin
            if ($urandom_range(0, 9) < 6) begin
              pend[d][c] = 1'b1;
              s_v[d][c]  = 1'b1;
              s_w[d][c]  = $urandom_range(0, 1) == 1;
              s_a[d][c]  = AW'($urandom_range(0, 15));
              s_d[d][c]  = VW'($urandom);
            end else begin
              s_v[d][c] = 1'b0;
            end
          end
      drive();
      #1;
      g0 = mgrant(0, 1);
      g1 = mgrant(1, 2);
      chk("rand grant p1", 32'(ifa.req_grant), 32'(g0));
      chk("rand grant p2", 32'(ifb.req_grant), 32'(g1));
      for (int d = 0; d < 2; d++) begin
        gd = d ? ifb.req_grant : ifa.req_grant;
        for (int c = 0; c < NC; c++) begin
          if (reset) begin
            pend[d][c] = 1'b0;
            wt[d][c]   = 0;
          end else if (pend[d][c]) begin
            if (gd[c]) begin
              chk($sformatf("fairness p%0d c%0d", d + 1, c), 32'(wt[d][c] + 1 <= (d ? 2 : 4)), 32'd1);
              pend[d][c] = 1'b0;
              wt[d][c]   = 0;
            end else begin
              wt[d][c]++;
            end
          end
        end
      end
      @(posedge clk);
      mupdate(0, g0);
      mupdate(1, g1);
      @(negedge clk);
      chk("rand rsp_valid p1", 32'(ifa.rsp_valid), 32'(m_rv[0]));
      chk("rand rsp_valid p2", 32'(ifb.rsp_valid), 32'(m_rv[1]));
      exp_rd = {m_rd[0][3], m_rd[0][2], m_rd[0][1], m_rd[0][0]};
      chk("rand rdata p1", ifa.rsp_rdata, exp_rd);
      exp_rd = {m_rd[1][3], m_rd[1][2], m_rd[1][1], m_rd[1][0]};
      chk("rand rdata p2", ifb.rsp_rdata, exp_rd);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
